// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter/sequencer sharing data_mem between the CPU MEM stage and the loader
module dmem_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  output logic         cpu_gnt,
  output logic         cpu_rvalid,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_stall,
  input  logic         dma_req,
  input  logic         dma_we,
  input  logic [N-1:0] dma_addr,
  input  logic [N-1:0] dma_wdata,
  output logic         dma_gnt,
  output logic         dma_rvalid,
  output logic [N-1:0] dma_rdata,
  output logic         err,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_data_in,
  output logic         mem_we,
  output logic         mem_read,
  input  logic [N-1:0] mem_data_out
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [N-1:0] DEPTH_W = N'(DEPTH);

  state_t       state, next_state;
  logic         owner;       // owner of the access in ISSUE: 0 = A (cpu), 1 = B (dma)
  logic         last_owner;
  logic         wr_q;
  logic         ok_q;
  logic         in_issue;
  logic         elig_a, elig_b, issue, win_b;
  logic [N-1:0] sel_addr, sel_wdata;
  logic         sel_we, sel_ok;

  assign in_issue = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    // The current owner still holds req during its gnt cycle, so mask it out.
    elig_a     = cpu_req & ~(in_issue & ~owner);
    elig_b     = dma_req & ~(in_issue & owner);
    issue      = elig_a | elig_b;
    win_b      = elig_b & (~elig_a | ~last_owner);
    sel_addr   = win_b ? dma_addr  : cpu_addr;
    sel_wdata  = win_b ? dma_wdata : cpu_wdata;
    sel_we     = win_b ? dma_we    : cpu_we;
    sel_ok     = (sel_addr < DEPTH_W);
    if (issue) next_state = ISSUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      wr_q        <= 1'b0;
      ok_q        <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      mem_read    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      dma_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
    end else begin
      cpu_rvalid <= in_issue & ~owner & ~wr_q;
      dma_rvalid <= in_issue & owner & ~wr_q;
      if (in_issue && !wr_q) begin
        if (owner) dma_rdata <= ok_q ? mem_data_out : '0;
        else       cpu_rdata <= ok_q ? mem_data_out : '0;
      end
      if (issue) begin
        owner       <= win_b;
        last_owner  <= win_b;
        wr_q        <= sel_we;
        ok_q        <= sel_ok;
        mem_address <= sel_addr;
        mem_data_in <= sel_wdata;
        mem_we      <= sel_we & sel_ok;
        mem_read    <= ~sel_we & sel_ok;
      end else begin
        mem_we   <= 1'b0;
        mem_read <= 1'b0;
      end
    end
  end

  assign cpu_gnt   = in_issue & ~owner;
  assign dma_gnt   = in_issue & owner;
  assign err       = in_issue & ~ok_q;
  assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural data_mem
module tb_dmem_arbiter;
  localparam int N = 32;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we, dma_req, dma_we;
  logic [N-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic         cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, err;
  logic [N-1:0] cpu_rdata, dma_rdata;
  logic [N-1:0] mem_address, mem_data_in, mem_data_out;
  logic         mem_we, mem_read;
  logic [N-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .err(err), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_read(mem_read), .mem_data_out(mem_data_out)
  );

  // data_mem: writes at negedge, combinational read
  always @(negedge clk) begin
    if (mem_we && mem_address < DEPTH) mem[mem_address[4:0]] <= mem_data_in;
  end
  assign mem_data_out = (mem_address < DEPTH) ? mem[mem_address[4:0]] : '0;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    cyc; cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, err, mem_we, mem_read, cpu_stall} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, err, mem_we, mem_read, cpu_stall});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_address, mem_data_in} !== 128'b0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0", cpu_rdata, dma_rdata, mem_address, mem_data_in);
    end
  endtask

  task automatic test_single_read;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL single_T: stall=%b gnt=%b expected 1 0", cpu_stall, cpu_gnt);
    end
    cyc;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_read !== 1'b1 || mem_we !== 1'b0 || mem_address !== 32'd5 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL single_T1: gnt=%b rd=%b we=%b addr=%0d stall=%b expected 1 1 0 5 0",
        cpu_gnt, mem_read, mem_we, mem_address, cpu_stall);
    end
    cpu_req = 0;
    cyc;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd5 || cpu_gnt !== 1'b0 || mem_read !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL single_T2: rvalid=%b rdata=%0d gnt=%b rd=%b stall=%b expected 1 5 0 0 0",
        cpu_rvalid, cpu_rdata, cpu_gnt, mem_read, cpu_stall);
    end
    cyc;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_rvalid_pulse: rvalid=%b expected 0", cpu_rvalid);
    end
  endtask

  task automatic test_tie_back_to_back;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 3;
    dma_req = 1; dma_we = 1; dma_addr = 10; dma_wdata = 32'hAA;
    cyc;
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_address !== 32'd3 || dma_req && dma_gnt) begin
      errors++; $display("FAIL tie_first: cpu_gnt=%b dma_gnt=%b addr=%0d expected 1 0 3", cpu_gnt, dma_gnt, mem_address);
    end
    cpu_req = 0;
    cyc;
    checks++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_we !== 1'b1 || mem_address !== 32'd10 || mem_data_in !== 32'hAA) begin
      errors++; $display("FAIL tie_second: dma_gnt=%b cpu_gnt=%b we=%b addr=%0d din=%h expected 1 0 1 10 aa",
        dma_gnt, cpu_gnt, mem_we, mem_address, mem_data_in);
    end
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd3) begin
      errors++; $display("FAIL tie_cpu_rdata: rvalid=%b rdata=%0d expected 1 3", cpu_rvalid, cpu_rdata);
    end
    dma_req = 0;
    cyc;
    checks++;
    if (dma_rvalid !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL tie_write_no_rvalid: dma_rvalid=%b we=%b expected 0 0", dma_rvalid, mem_we);
    end
    cpu_req = 1; cpu_addr = 10;
    cyc;
    cpu_req = 0;
    cyc;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hAA) begin
      errors++; $display("FAIL tie_readback: rvalid=%b rdata=%h expected 1 aa", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_alternate;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 1;
    dma_req = 1; dma_we = 0; dma_addr = 2;
    for (int k = 1; k <= 8; k++) begin
      cyc;
      checks++;
      if (cpu_gnt !== k[0] || dma_gnt !== ~k[0]) begin
        errors++; $display("FAIL alt_gnt_%0d: cpu_gnt=%b dma_gnt=%b expected %b %b", k, cpu_gnt, dma_gnt, k[0], ~k[0]);
      end
      if (k >= 2) begin
        checks++;
        if (cpu_rvalid !== ~k[0] || dma_rvalid !== k[0] ||
            (cpu_rvalid && cpu_rdata !== 32'd1) || (dma_rvalid && dma_rdata !== 32'd2)) begin
          errors++; $display("FAIL alt_rvalid_%0d: cpu=%b/%0d dma=%b/%0d", k, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata);
        end
      end
    end
    cpu_req = 0; dma_req = 0;
    cyc; cyc;
  endtask

  task automatic test_out_of_range;
    do_reset;
    dma_req = 1; dma_we = 1; dma_addr = 40; dma_wdata = 32'hDEAD;
    cyc;
    checks++;
    if (dma_gnt !== 1'b1 || err !== 1'b1 || mem_we !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL oor_write: gnt=%b err=%b we=%b rd=%b expected 1 1 0 0", dma_gnt, err, mem_we, mem_read);
    end
    dma_req = 0;
    cyc;
    checks++;
    if (err !== 1'b0 || dma_rvalid !== 1'b0) begin
      errors++; $display("FAIL oor_err_pulse: err=%b rvalid=%b expected 0 0", err, dma_rvalid);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 8;
    cyc;
    cpu_req = 0;
    cyc;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd8) begin
      errors++; $display("FAIL oor_mem_intact: rvalid=%b rdata=%0d expected 1 8", cpu_rvalid, cpu_rdata);
    end
    dma_req = 1; dma_we = 0; dma_addr = DEPTH - 1;
    cyc;
    checks++;
    if (err !== 1'b0 || mem_read !== 1'b1) begin
      errors++; $display("FAIL oor_last_word: err=%b rd=%b expected 0 1", err, mem_read);
    end
    dma_addr = DEPTH;
    cyc;
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'd31) begin
      errors++; $display("FAIL oor_last_data: rvalid=%b rdata=%0d expected 1 31", dma_rvalid, dma_rdata);
    end
    cyc;
    checks++;
    if (dma_gnt !== 1'b1 || err !== 1'b1 || mem_read !== 1'b0) begin
      errors++; $display("FAIL oor_read: gnt=%b err=%b rd=%b expected 1 1 0", dma_gnt, err, mem_read);
    end
    dma_req = 0;
    cyc;
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'd0) begin
      errors++; $display("FAIL oor_read_zero: rvalid=%b rdata=%0d expected 1 0", dma_rvalid, dma_rdata);
    end
  endtask

  task automatic test_reset_in_issue;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 7;
    cyc;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_address !== 32'd7) begin
      errors++; $display("FAIL rst_issue_pre: gnt=%b addr=%0d expected 1 7", cpu_gnt, mem_address);
    end
    rst = 1; cpu_req = 0;
    cyc;
    rst = 0;
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, err, mem_we, mem_read} !== 7'b0 ||
        cpu_rdata !== 32'd0 || mem_address !== 32'd0 || mem_data_in !== 32'd0) begin
      errors++; $display("FAIL rst_issue_post: ctrl=%b rdata=%0d addr=%0d expected 0 0 0",
        {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, err, mem_we, mem_read}, cpu_rdata, mem_address);
    end
    cyc;
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_issue_idle: rvalid=%b gnt=%b expected 0 0", cpu_rvalid, cpu_gnt);
    end
    cpu_req = 1; cpu_addr = 4; dma_req = 1; dma_we = 0; dma_addr = 6;
    cyc;
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_issue_pointer: cpu_gnt=%b dma_gnt=%b expected 1 0", cpu_gnt, dma_gnt);
    end
    cpu_req = 0;
    cyc;
    dma_req = 0;
    cyc;
  endtask

  task automatic test_back_to_back;
    int first_gnt;
    int second_gnt;
    first_gnt = -1;
    second_gnt = -1;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 2;
    for (int c = 1; c <= 8; c++) begin
      cyc;
      if (cpu_rvalid) begin
        checks++;
        if (cpu_rdata !== ((second_gnt < 0) ? 32'd2 : 32'd4)) begin
          errors++; $display("FAIL b2b_rdata_%0d: rdata=%0d expected %0d", c, cpu_rdata, (second_gnt < 0) ? 2 : 4);
        end
      end
      if (cpu_gnt) begin
        if (first_gnt < 0) begin
          first_gnt = c; cpu_addr = 4;
        end else if (second_gnt < 0) begin
          second_gnt = c; cpu_req = 0;
        end
      end
    end
    checks++;
    if (first_gnt != 1 || second_gnt != 3) begin
      errors++; $display("FAIL b2b_gnt_spacing: first=%0d second=%0d expected 1 3", first_gnt, second_gnt);
    end
    checks++;
    if (cpu_rdata !== 32'd4 || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_hold: rdata=%0d rvalid=%b expected 4 0", cpu_rdata, cpu_rvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = i;
    test_reset;
    test_single_read;
    test_tie_back_to_back;
    test_alternate;
    test_out_of_range;
    test_reset_in_issue;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
